mmio_io_bridge: RTL and testbench

- Sits between the CPU core's port-A load/store interface and the single-clock RAM.
- Decodes a parametrised I/O window above IO_BASE and routes accesses there to on-chip peripheral registers instead of RAM:
  - a PS/2 key-event FIFO (generalises single-key detection to any scancode, with buffering),
  - a display output register,
  - a free-running timer with compare and interrupt.
- Read timing matches the synchronous RAM, so the control FSM sees one uniform one-cycle read latency for RAM and I/O.

---
 rtl/mmio_io_bridge.sv | 154 +++++++++++++++
 tb/tb_mmio_io_bridge.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_bridge.sv
// Bridge between the CPU port-A load/store interface and the synchronous RAM.
// Addresses at or above IO_BASE go to a key FIFO, a display register and a compare timer.
module mmio_io_bridge #(
  parameter int                DATA_W     = 16,
  parameter int                ADDR_W     = 16,
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(16'hFF00),
  parameter int                FIFO_DEPTH = 8,
  parameter int                TIMER_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q,
  input  logic              key_valid,
  input  logic [7:0]        key_code,
  output logic [DATA_W-1:0] out_reg,
  output logic              irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_W-1:0] OFF_KEY_DATA = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] OFF_KEY_STAT = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] OFF_OUT      = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] OFF_TIMER    = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] OFF_TCMP     = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] OFF_IRQ      = ADDR_W'(5);

  logic              is_io;
  logic [ADDR_W-1:0] off;
  logic              sel_io_q;
  logic [DATA_W-1:0] io_rdata_q;
  logic [DATA_W-1:0] io_rdata_d;

  logic [7:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              overflow;
  logic              pop;
  logic              push;
  logic              ovf_set;

  logic [TIMER_W-1:0] timer_cnt;
  logic [TIMER_W-1:0] timer_cmp;
  logic               timer_hit;
  logic               timer_pending;

  logic wr_stat;
  logic wr_out;
  logic wr_timer;
  logic wr_tcmp;
  logic wr_irq;

  assign is_io  = (cpu_addr >= IO_BASE);
  assign off    = cpu_addr - IO_BASE;
  assign ram_we = cpu_we & ~is_io;

  assign wr_stat  = cpu_we & is_io & (off == OFF_KEY_STAT);
  assign wr_out   = cpu_we & is_io & (off == OFF_OUT);
  assign wr_timer = cpu_we & is_io & (off == OFF_TIMER);
  assign wr_tcmp  = cpu_we & is_io & (off == OFF_TCMP);
  assign wr_irq   = cpu_we & is_io & (off == OFF_IRQ);

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);

  // A pop frees a slot in the same cycle, so a push while full still lands.
  assign pop     = cpu_re & is_io & (off == OFF_KEY_DATA) & ~fifo_empty;
  assign push    = key_valid & (~fifo_full | pop);
  assign ovf_set = key_valid & fifo_full & ~pop;

  assign timer_hit = (timer_cnt == timer_cmp);
  assign irq       = timer_pending | ~fifo_empty;
  assign cpu_rdata = sel_io_q ? io_rdata_q : ram_q;

  always_comb begin
    io_rdata_d = '0;
    if (is_io) begin
      case (off)
        OFF_KEY_DATA: if (!fifo_empty) io_rdata_d[7:0] = fifo_mem[rd_ptr];
        OFF_KEY_STAT: begin
          io_rdata_d[15]        = overflow;
          io_rdata_d[14]        = fifo_full;
          io_rdata_d[13]        = fifo_empty;
          io_rdata_d[CNT_W-1:0] = count;
        end
        OFF_OUT:   io_rdata_d = out_reg;
        OFF_TIMER: io_rdata_d[TIMER_W-1:0] = timer_cnt;
        OFF_TCMP:  io_rdata_d[TIMER_W-1:0] = timer_cmp;
        OFF_IRQ: begin
          io_rdata_d[0] = timer_pending;
          io_rdata_d[1] = ~fifo_empty;
        end
        default: io_rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_io_q   <= 1'b0;
      io_rdata_q <= '0;
    end else begin
      sel_io_q   <= is_io;
      io_rdata_q <= io_rdata_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the count.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= key_code;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (ovf_set)      overflow <= 1'b1;
      else if (wr_stat) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_cnt     <= '0;
      timer_cmp     <= '0;
      timer_pending <= 1'b0;
      out_reg       <= '0;
    end else begin
      if (wr_timer) timer_cnt <= cpu_wdata[TIMER_W-1:0];
      else          timer_cnt <= timer_cnt + TIMER_W'(1);
      if (wr_tcmp) timer_cmp <= cpu_wdata[TIMER_W-1:0];
      if (wr_out)  out_reg   <= cpu_wdata;
      if (timer_hit)                  timer_pending <= 1'b1;
      else if (wr_irq && cpu_wdata[0]) timer_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Self-checking bench for mmio_io_bridge: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the register map.
module tb_mmio_io_bridge;

  localparam int DEPTH = 8;
  localparam logic [15:0] IO_BASE = 16'hFF00;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [15:0] cpu_rdata;
  logic        ram_we;
  logic [15:0] ram_q = 16'h5A5A;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = '0;
  logic [15:0] out_reg;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;
  bit run = 1'b1;

  logic [7:0]  kq[$];
  logic        m_ovf = 1'b0;
  logic [15:0] m_cnt = '0;
  logic [15:0] m_cmp = '0;
  logic [15:0] m_out = '0;
  logic        m_pend = 1'b0;
  logic        m_sel = 1'b0;
  logic [15:0] m_io = '0;

  mmio_io_bridge dut (
    .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_rdata(cpu_rdata), .ram_we(ram_we),
    .ram_q(ram_q), .key_valid(key_valid), .key_code(key_code),
    .out_reg(out_reg), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_read(input logic [15:0] off);
    logic [15:0] v;
    v = '0;
    case (off)
      16'd0: if (kq.size() > 0) v = {8'h00, kq[0]};
      16'd1: v = {m_ovf, kq.size() == DEPTH, kq.size() == 0, 5'b0, 8'(kq.size())};
      16'd2: v = m_out;
      16'd3: v = m_cnt;
      16'd4: v = m_cmp;
      16'd5: v = {14'b0, kq.size() != 0, m_pend};
      default: v = '0;
    endcase
    return v;
  endfunction

  // Reference model: registered read value and peripheral state after each edge.
  always @(posedge clk or negedge reset) begin
    logic io;
    logic [15:0] off;
    logic [15:0] rv;
    bit hit;
    if (!reset) begin
      kq.delete();
      m_ovf = 0; m_cnt = 0; m_cmp = 0; m_out = 0; m_pend = 0; m_sel = 0; m_io = 0;
    end else begin
      io  = (cpu_addr >= IO_BASE);
      off = cpu_addr - IO_BASE;
      rv  = io ? model_read(off) : 16'h0;
      hit = (m_cnt == m_cmp);
      if (io && off == 16'd0 && cpu_re && kq.size() > 0) void'(kq.pop_front());
      if (io && off == 16'd1 && cpu_we) m_ovf = 1'b0;
      if (key_valid) begin
        if (kq.size() < DEPTH) kq.push_back(key_code);
        else m_ovf = 1'b1;
      end
      if (io && off == 16'd2 && cpu_we) m_out = cpu_wdata;
      if (io && off == 16'd4 && cpu_we) m_cmp = cpu_wdata;
      m_cnt = (io && off == 16'd3 && cpu_we) ? cpu_wdata : m_cnt + 16'd1;
      if (io && off == 16'd5 && cpu_we && cpu_wdata[0]) m_pend = 1'b0;
      if (hit) m_pend = 1'b1;
      m_sel = io;
      m_io  = rv;
    end
  end

  always @(negedge clk) begin
    if (run) begin
      check_output("cpu_rdata", 32'(cpu_rdata), 32'(m_sel ? m_io : ram_q));
      check_output("out_reg", 32'(out_reg), 32'(m_out));
      check_output("irq", 32'(irq), 32'(m_pend || kq.size() != 0));
      check_output("ram_we", 32'(ram_we), 32'(cpu_we && (cpu_addr < IO_BASE)));
    end
  end

  task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] wd, input logic we,
                                input logic re, input logic kv, input logic [7:0] kc);
    cpu_addr = a; cpu_wdata = wd; cpu_we = we; cpu_re = re;
    key_valid = kv; key_code = kc; ram_q = 16'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic [15:0] a, input logic [15:0] wd, input logic we,
                     input logic re, input logic kv, input logic [7:0] kc);
    apply_stimulus(a, wd, we, re, kv, kc);
    tick();
  endtask

  task automatic push_code(input logic [7:0] kc);
    cyc(16'h0010, 16'h0, 1'b0, 1'b0, 1'b1, kc);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) cyc(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
  endtask

  initial begin
    logic [15:0] a;
    #23;
    check_output("reset out_reg", 32'(out_reg), 32'h0);
    check_output("reset irq", 32'(irq), 32'h0);
    check_output("reset cpu_rdata", 32'(cpu_rdata), 32'(ram_q));
    @(posedge clk); #2; reset = 1'b1;

    apply_stimulus(16'h0010, 16'h1234, 1'b1, 1'b0, 1'b0, 8'h0); #1;
    check_output("ram store we", 32'(ram_we), 32'h1); tick();
    apply_stimulus(16'hFF02, 16'hBEEF, 1'b1, 1'b0, 1'b0, 8'h0); #1;
    check_output("io store we", 32'(ram_we), 32'h0); tick();
    check_output("out_reg beef", 32'(out_reg), 32'hBEEF);
    cyc(16'hFF02, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    check_output("read out", 32'(cpu_rdata), 32'hBEEF);
    cyc(16'hFF04, 16'h8000, 1'b1, 1'b0, 1'b0, 8'h0);
    cyc(16'hFF05, 16'h0001, 1'b1, 1'b0, 1'b0, 8'h0);
    cyc(16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("irq idle", 32'(irq), 32'h0);

    push_code(8'h29); push_code(8'h1C); push_code(8'hF0);
    cyc(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("stat 3", 32'(cpu_rdata), 32'h0003);
    check_output("irq key", 32'(irq), 32'h1);
    cyc(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    check_output("pop 29", 32'(cpu_rdata), 32'h0029);
    cyc(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    check_output("pop 1C", 32'(cpu_rdata), 32'h001C);
    cyc(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    check_output("pop F0", 32'(cpu_rdata), 32'h00F0);
    cyc(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("stat empty", 32'(cpu_rdata), 32'h2000);
    check_output("irq empty", 32'(irq), 32'h0);
    cyc(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    check_output("pop empty", 32'(cpu_rdata), 32'h0000);

    for (int i = 0; i < 9; i++) push_code(8'(8'h40 + i));
    cyc(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("stat overflow", 32'(cpu_rdata), 32'hC008);
    cyc(16'hFF00, 16'h0, 1'b0, 1'b1, 1'b1, 8'h77);
    check_output("pop while full", 32'(cpu_rdata), 32'h0040);
    cyc(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("stat full kept", 32'(cpu_rdata), 32'hC008);
    cyc(16'hFF01, 16'h0, 1'b1, 1'b0, 1'b0, 8'h0);
    cyc(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("stat ovf cleared", 32'(cpu_rdata), 32'h4008);
    drain();

    cyc(16'hFF03, 16'hFFFE, 1'b1, 1'b0, 1'b0, 8'h0);
    cyc(16'hFF04, 16'h0001, 1'b1, 1'b0, 1'b0, 8'h0);
    cyc(16'hFF03, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    check_output("timer ffff", 32'(cpu_rdata), 32'hFFFF);
    check_output("irq before hit", 32'(irq), 32'h0);
    cyc(16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("irq at hit", 32'(irq), 32'h0);
    cyc(16'h0010, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("irq pending", 32'(irq), 32'h1);
    cyc(16'hFF05, 16'h0001, 1'b1, 1'b0, 1'b0, 8'h0);
    check_output("irq cleared", 32'(irq), 32'h0);

    push_code(8'h11); push_code(8'h22); push_code(8'h33);
    cyc(16'hFF02, 16'h0005, 1'b1, 1'b0, 1'b0, 8'h0);
    check_output("out_reg 5", 32'(out_reg), 32'h5);
    reset = 1'b0; #1;
    check_output("mid reset out_reg", 32'(out_reg), 32'h0);
    check_output("mid reset irq", 32'(irq), 32'h0);
    check_output("mid reset rdata", 32'(cpu_rdata), 32'(ram_q));
    @(posedge clk); #2; reset = 1'b1;
    cyc(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("stat after reset", 32'(cpu_rdata), 32'h2000);
    cyc(16'h0010, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    check_output("ram passthrough", 32'(cpu_rdata), 32'(ram_q));
    cyc(16'hFF04, 16'h8000, 1'b1, 1'b0, 1'b0, 8'h0);
    cyc(16'hFF05, 16'h0001, 1'b1, 1'b0, 1'b0, 8'h0);

    push_code(8'h5A); push_code(8'h33);
    for (int i = 0; i < 3; i++) begin
      cyc(16'hFF00, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
      check_output("peek head", 32'(cpu_rdata), 32'h005A);
    end
    cyc(16'hFF01, 16'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    check_output("stat after peek", 32'(cpu_rdata), 32'h0002);
    cyc(16'hFF07, 16'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    check_output("unmapped read", 32'(cpu_rdata), 32'h0000);
    drain();

    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 7))
        0, 1:    a = 16'($urandom_range(0, 16'hFEFF));
        2:       a = 16'($urandom_range(16'hFF08, 16'hFFFF));
        default: a = 16'(16'hFF00 + $urandom_range(0, 5));
      endcase
      cyc(a, 16'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
